// File: rtl/mem_port_b_reader_pkg.sv
// ----------------------------------------------------------------------------
// mem_reader_pkg
// Shared definitions for the data-memory port-B bulk reader: default widths
// and the controller state encoding.
// ----------------------------------------------------------------------------
package mem_reader_pkg;

    localparam int ADDR_W_DEF = 18;   // port-B address width (2^18 words)
    localparam int DATA_W_DEF = 24;   // memory word width
    localparam int CNT_W_DEF  = 18;   // word_count command field width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_e;

endpackage

// File: rtl/mem_port_b_reader_if.sv
// ----------------------------------------------------------------------------
// mem_port_b_reader_if
// Valid/ready word stream carrying memory words out of the port-B reader.
//   out_valid : word available (source -> sink)
//   out_ready : sink accepts the word (sink -> source)
//   out_data  : stream word
//   out_last  : final word of the transfer
// master = stream source (the reader), slave = stream sink.
// ----------------------------------------------------------------------------
interface mem_port_b_reader_if #(
    parameter int DATA_W = 24
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_port_b_reader_skid_fifo.sv
// ----------------------------------------------------------------------------
// reader_skid_fifo
// Two-entry FIFO holding {last, data} words returned from memory.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO and
//                zeroes the storage so the head reads 0)
//   push       : write push_data this cycle
//   push_data  : {last, data}
//   pop        : consume the head this cycle
//   head_data  : current head entry
//   full/empty : occupancy flags
//   count      : occupancy (0..2), used by the read-issue credit logic
// A simultaneous push and pop is legal, including when full.
// ----------------------------------------------------------------------------
module reader_skid_fifo #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] entry_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Qualify requests so a stray pop/push can never corrupt the pointers.
    always_comb begin
        pop_ok_s  = pop & (count_r != 2'd0);
        push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_r[0] <= {W{1'b0}};
            entry_r[1] <= {W{1'b0}};
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                entry_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = entry_r[rd_ptr_r];
    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign count     = count_r;

endmodule

// File: rtl/mem_port_b_reader.sv
// ----------------------------------------------------------------------------
// mem_port_b_reader
// Bulk reader for the data memory's port B. A start command sweeps a
// contiguous (modulo 2^ADDR_W) address range and streams the words out over
// a valid/ready interface while the pipeline keeps port A.
//   clk, rst     : clock (also clocks memory port B), sync active-high reset
//   start        : command strobe, accepted only when idle
//   base_addr    : first word address, sampled on an accepted start
//   word_count   : number of words, sampled on an accepted start
//   busy         : transfer in progress (low in the done cycle)
//   done         : one-cycle end-of-transfer pulse
//   address_b    : memory port-B address
//   read_data_b  : memory port-B read data, one cycle after address_b
//   stream       : out_valid/out_ready/out_data/out_last word stream
// address_b always shows the address of the read being issued in that cycle,
// so the word returns on read_data_b the following cycle and is pushed into
// the FIFO at that edge. A read is issued only if the FIFO plus the read in
// flight, net of this cycle's pop, holds fewer than two words, so the FIFO
// can never overflow.
// ----------------------------------------------------------------------------
module mem_port_b_reader
    import mem_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] read_data_b,
    mem_port_b_reader_if.master stream
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    reader_state_e     state_r;
    logic [ADDR_W-1:0] address_b_r;
    logic [CNT_W-1:0]  remaining_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              busy_r;
    logic              done_r;

    logic [DATA_W:0]   fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [1:0]        fifo_count_s;
    logic              pop_s;
    logic [2:0]        occupancy_s;
    logic              issue_s;
    logic              drain_done_s;

    // Issue credit and drain completion, both looking at this cycle's pop.
    always_comb begin
        pop_s       = ~fifo_empty_s & stream.out_ready;
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if ((state_r == READ) && (remaining_r != CNT_ZERO) &&
            (occupancy_s < 3'd2) && !(fifo_full_s && !pop_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        // Finishing on the pop of the last word puts done in the next cycle.
        if (!inflight_r &&
            ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s))) begin
            drain_done_s = 1'b1;
        end else begin
            drain_done_s = 1'b0;
        end
    end

    // Controller: state, address/range counters, read tracking, busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            address_b_r     <= {ADDR_W{1'b0}};
            remaining_r     <= CNT_ZERO;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (remaining_r == CNT_ONE);
            done_r          <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        address_b_r <= base_addr;
                        remaining_r <= word_count;
                        if (word_count != CNT_ZERO) begin
                            state_r <= READ;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                READ: begin
                    busy_r <= 1'b1;
                    if (issue_s) begin
                        remaining_r <= remaining_r - CNT_ONE;
                        // Advance only while more reads follow, so address_b
                        // holds the final address once the sweep is issued.
                        if (remaining_r == CNT_ONE) begin
                            state_r <= DRAIN;
                        end else begin
                            address_b_r <= address_b_r + ADDR_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    reader_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data ({inflight_last_r, read_data_b}),
        .pop       (pop_s),
        .head_data (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign busy             = busy_r;
    assign done             = done_r;
    assign address_b        = address_b_r;
    assign stream.out_valid = ~fifo_empty_s;
    assign stream.out_data  = fifo_head_s[DATA_W-1:0];
    assign stream.out_last  = fifo_head_s[DATA_W];

endmodule

// File: tb/tb_mem_port_b_reader.sv
// ----------------------------------------------------------------------------
// tb_mem_port_b_reader
// Self-checking bench: a synchronous 1-cycle RAM model feeds the reader; the
// expected stream is built as a queue of {last, mem[base+i]} words.
// ----------------------------------------------------------------------------
module tb_mem_port_b_reader;

    localparam int AW = 18;
    localparam int DW = 24;
    localparam int CW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] address_b;
    logic [DW-1:0] read_data_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int vectors     = 0;
    int miscompares = 0;

    mem_port_b_reader_if #(.DATA_W(DW)) stream_if ();

    mem_port_b_reader #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .address_b   (address_b),
        .read_data_b (read_data_b),
        .stream      (stream_if.master)
    );

    always #5 clk = ~clk;

    // Synchronous RAM port B: data for the address presented in a cycle
    // appears in the following cycle.
    always @(posedge clk) read_data_b <= mem[address_b];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer. mode: 0 ready always, 1 ready pattern 1,0,0,..., 2 random.
    // inject_at: cycle at which a stray start is pulsed (-1 none).
    // abort_after: reset after this many accepted beats (-1 none).
    task automatic run_transfer(input logic [AW-1:0] b, input int n, input int mode,
                                input int inject_at, input int abort_after, input string tag);
        logic [DW:0]   exp_q [$];
        logic [DW:0]   head;
        logic [DW:0]   held;
        logic          held_valid = 1'b0;
        logic [AW-1:0] a;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] idx;
        logic          hs;
        logic          exp_busy;
        int accepted = 0, changes = 0, done_cnt = 0, done_cyc = -1;
        int first_cyc = -1, last_cyc = -1, valid_seen = 0;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_q.push_back({(i == n - 1), mem[a]});
        end
        base_addr = b;
        word_count = CW'(n);
        start = 1'b1;
        stream_if.out_ready = 1'b0;
        step();
        start = 1'b0;
        base_addr = AW'($urandom);
        word_count = CW'($urandom);
        prev_addr = address_b;
        for (int cyc = 1; cyc < 400; cyc++) begin
            case (mode)
                0:       stream_if.out_ready = 1'b1;
                1:       stream_if.out_ready = ((cyc - 1) % 3 == 0);
                default: stream_if.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == inject_at) begin
                start = 1'b1;
                base_addr = AW'($urandom);
                word_count = 18'd5;
            end else begin
                start = 1'b0;
            end
            if (held_valid) begin
                vectors++;
                if ({stream_if.out_valid, stream_if.out_last, stream_if.out_data} !== {1'b1, held}) begin
                    miscompares++;
                    $display("FAIL %s stall_hold cyc=%0d got v=%0b %h want held %h", tag, cyc,
                             stream_if.out_valid, {stream_if.out_last, stream_if.out_data}, held);
                end
            end
            exp_busy = (n != 0) && !(last_cyc >= 0 && cyc > last_cyc);
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL %s busy cyc=%0d got %0b want %0b", tag, cyc, busy, exp_busy);
            end
            if (n != 0 && exp_busy) begin
                idx = address_b - b;
                vectors++;
                if ((cyc == 1 && address_b !== b) ||
                    (cyc > 1 && address_b !== prev_addr && address_b !== prev_addr + 18'd1) ||
                    int'(idx) > accepted + 2 || int'(idx) >= n) begin
                    miscompares++;
                    $display("FAIL %s address_b cyc=%0d got %h prev %h base %h accepted %0d",
                             tag, cyc, address_b, prev_addr, b, accepted);
                end
                if (cyc > 1 && address_b !== prev_addr) changes++;
            end
            prev_addr = address_b;
            hs = stream_if.out_valid & stream_if.out_ready;
            if (stream_if.out_valid) valid_seen = 1;
            if (hs) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_beat cyc=%0d got %h want none", tag, cyc, stream_if.out_data);
                end else begin
                    head = exp_q.pop_front();
                    if ({stream_if.out_last, stream_if.out_data} !== head) begin
                        miscompares++;
                        $display("FAIL %s beat%0d got %h want %h", tag, accepted,
                                 {stream_if.out_last, stream_if.out_data}, head);
                    end
                end
                accepted++;
                if (first_cyc < 0) first_cyc = cyc;
                if (accepted == n) last_cyc = cyc;
            end
            held_valid = stream_if.out_valid & ~stream_if.out_ready;
            held = {stream_if.out_last, stream_if.out_data};
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hs && accepted == abort_after) begin
                step();
                rst = 1'b1;
                step();
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    vectors++;
                    if ({busy, done, stream_if.out_valid} !== 3'b000 ||
                        (k == 0 && {stream_if.out_last, stream_if.out_data} !== {1'b0, 24'h000000})) begin
                        miscompares++;
                        $display("FAIL %s after_abort k=%0d got busy=%0b done=%0b v=%0b d=%h want all 0",
                                 tag, k, busy, done, stream_if.out_valid, stream_if.out_data);
                    end
                    stream_if.out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                return;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            step();
        end
        vectors++;
        if (accepted != n || done_cnt != 1) begin
            miscompares++;
            $display("FAIL %s totals got beats=%0d dones=%0d want beats=%0d dones=1", tag, accepted, done_cnt, n);
        end
        vectors++;
        if (done_cyc != ((n == 0) ? 1 : last_cyc + 1)) begin
            miscompares++;
            $display("FAIL %s done_timing got cyc %0d want %0d", tag, done_cyc, (n == 0) ? 1 : last_cyc + 1);
        end
        if (n == 0) begin
            vectors++;
            if (valid_seen != 0) begin
                miscompares++;
                $display("FAIL %s zero_len_valid got out_valid seen want never", tag);
            end
        end else begin
            vectors++;
            if (changes != n - 1) begin
                miscompares++;
                $display("FAIL %s address_steps got %0d want %0d", tag, changes, n - 1);
            end
        end
        if (mode == 0 && n > 0) begin
            vectors++;
            if (first_cyc != 3 || last_cyc != 2 + n) begin
                miscompares++;
                $display("FAIL %s throughput got first=%0d last=%0d want first=3 last=%0d",
                         tag, first_cyc, last_cyc, 2 + n);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        base_addr = 18'h00000;
        word_count = 18'h00000;
        stream_if.out_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if ({busy, done, stream_if.out_valid, stream_if.out_last, address_b, stream_if.out_data} !== 46'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%0b done=%0b v=%0b l=%0b a=%h d=%h want all 0",
                     busy, done, stream_if.out_valid, stream_if.out_last, address_b, stream_if.out_data);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({busy, done, stream_if.out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b v=%0b want 0", busy, done, stream_if.out_valid);
        end
    endtask

    task automatic test_basic();
        run_transfer(18'h00010, 4, 0, -1, -1, "basic");
    endtask

    task automatic test_stall();
        run_transfer(18'h00010, 4, 1, -1, -1, "stall");
        run_transfer(18'h00200, 9, 1, -1, -1, "stall_long");
    endtask

    task automatic test_wrap();
        run_transfer(18'h3FFFE, 4, 0, -1, -1, "wrap");
    endtask

    task automatic test_zero_count();
        run_transfer(18'h00123, 0, 0, -1, -1, "zero");
    endtask

    task automatic test_restart_ignored();
        run_transfer(18'h01000, 8, 2, 4, -1, "restart");
    endtask

    task automatic test_abort();
        run_transfer(18'h02000, 8, 0, -1, 3, "abort");
        run_transfer(18'h05555, 6, 2, -1, -1, "after_abort");
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        logic [AW-1:0] a;
        int n;
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom);
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                a = b + AW'(i);
                mem[a] = DW'($urandom);
            end
            run_transfer(b, n, 2, -1, -1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i) + 24'h000100;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_count();
        test_restart_ignored();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
